// File: rtl/fire.sv
// Fire-detection controller: a three-state Moore FSM that escalates from
// IDLE to ALARM on smoke, and from ALARM to EXTINGUISH on heat.
// Outputs depend only on the registered state; sensors never reach the
// outputs combinationally, so every sensor change shows up one edge later.
module fire (
    input  logic clk,
    input  logic reset,
    input  logic heat_signal,
    input  logic smoke_signal,
    output logic alarm,
    output logic extinguish
);

    localparam logic [1:0] IDLE       = 2'b00;
    localparam logic [1:0] ALARM      = 2'b01;
    localparam logic [1:0] EXTINGUISH = 2'b10;

    // Kept under these exact names so benches can probe them hierarchically.
    logic [1:0] current_state;
    logic [1:0] next_state;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= IDLE;
        end else begin
            current_state <= next_state;
        end
    end

    // Next-state decode. Heat only escalates once an alarm is already up,
    // so EXTINGUISH is always at least two edges away from IDLE.
    always_comb begin
        next_state = IDLE;
        case (current_state)
            IDLE: begin
                if (smoke_signal) begin
                    next_state = ALARM;
                end else begin
                    next_state = IDLE;
                end
            end
            ALARM: begin
                if (heat_signal) begin
                    next_state = EXTINGUISH;
                end else if (smoke_signal) begin
                    next_state = ALARM;
                end else begin
                    next_state = IDLE;
                end
            end
            EXTINGUISH: begin
                if (heat_signal) begin
                    next_state = EXTINGUISH;
                end else if (smoke_signal) begin
                    next_state = ALARM;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                // The unused encoding recovers to IDLE on the next edge.
                next_state = IDLE;
            end
        endcase
    end

    // Moore output decode; the unused encoding drives both outputs low.
    always_comb begin
        alarm      = 1'b0;
        extinguish = 1'b0;
        case (current_state)
            ALARM: begin
                alarm      = 1'b1;
                extinguish = 1'b0;
            end
            EXTINGUISH: begin
                alarm      = 1'b1;
                extinguish = 1'b1;
            end
            default: begin
                alarm      = 1'b0;
                extinguish = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fire.sv
// Bench for the fire controller: directed scenarios followed by random
// sensor traffic, checked against a severity-level model through a queue.
module tb_fire;

    logic clk;
    logic reset;
    logic heat_signal;
    logic smoke_signal;
    logic alarm;
    logic extinguish;

    int checks = 0;
    int errors = 0;

    // Expected {alarm, extinguish, state[1:0]} after each driven edge.
    logic [3:0] exp_q[$];
    string      name_q[$];

    // Model: severity 0 = quiet, 1 = alarm, 2 = extinguishing.
    int sev = 0;

    fire dut (
        .clk          (clk),
        .reset        (reset),
        .heat_signal  (heat_signal),
        .smoke_signal (smoke_signal),
        .alarm        (alarm),
        .extinguish   (extinguish)
    );

    // Clock and input defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset        = 1'b1;
        heat_signal  = 1'b0;
        smoke_signal = 1'b0;
    end

    // Expected outputs and state code for a severity level.
    function automatic logic [3:0] expect_of(input int s);
        case (s)
            1:       return 4'b1001;
            2:       return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    // Drive one cycle of inputs and push what the next edge must produce.
    task automatic drive(input logic r, input logic s, input logic h, input string tag);
        @(negedge clk);
        reset        = r;
        smoke_signal = s;
        heat_signal  = h;
        if (r) begin
            sev = 0;
        end else if (h && sev >= 1) begin
            sev = 2;
        end else if (s) begin
            sev = 1;
        end else begin
            sev = 0;
        end
        exp_q.push_back(expect_of(sev));
        name_q.push_back(tag);
    endtask

    // Monitor: after every edge, compare the DUT with the oldest expectation.
    initial begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        string      tag;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = name_q.pop_front();
                act_v = {alarm, extinguish, dut.current_state};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got alarm/ext/state=%b required %b at %0t",
                             tag, act_v, exp_v, $time);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1);
    end

    // Stimulus sequence.
    initial begin
        // 1. reset, including smoke raised while reset is held
        drive(1, 0, 0, "reset_1");
        drive(1, 0, 0, "reset_2");
        drive(1, 1, 0, "reset_smoke");
        // 2. smoke only, then clear
        drive(0, 1, 0, "smoke_a");
        drive(0, 1, 0, "smoke_b");
        drive(0, 0, 0, "smoke_clear");
        // 3. full fire: smoke+heat together takes two edges to extinguish
        drive(0, 1, 1, "fire_first");
        drive(0, 1, 1, "fire_second");
        drive(0, 1, 1, "fire_hold");
        drive(0, 0, 1, "fire_hold_heat_only");
        // 4. extinction via alarm, then directly to idle
        drive(0, 1, 0, "ext_to_alarm");
        drive(0, 0, 0, "alarm_to_idle");
        drive(0, 1, 1, "refire_a");
        drive(0, 1, 1, "refire_b");
        drive(0, 0, 0, "ext_to_idle");
        // 5. heat alone never leaves idle
        drive(0, 0, 1, "heat_only_1");
        drive(0, 0, 1, "heat_only_2");
        drive(0, 0, 1, "heat_only_3");
        // 6. reset mid-operation, then resume with both sensors high
        drive(0, 1, 1, "mid_a");
        drive(0, 1, 1, "mid_b");
        drive(1, 1, 1, "mid_reset");
        drive(0, 1, 1, "post_reset_alarm");
        drive(0, 1, 1, "post_reset_ext");
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), "random");
        end
        // Drain: let the monitor consume the last expectation.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: queue holds %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fire.md
Name: fire

Overview:
- Fire-detection controller for the home-automation system.
- Watches two single-bit sensor inputs, smoke and heat, and drives an alarm output and an extinguisher-enable output.
- Implemented as a 3-state Moore FSM clocked by the system clock.
- Sits between the sensor front-ends and the alarm/sprinkler actuator drivers.

Parameters:
- None. State encoding is fixed by internal constants: IDLE=2'b00, ALARM=2'b01, EXTINGUISH=2'b10.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- heat_signal  input  1  heat sensor; 1 = over-temperature detected
- smoke_signal  input  1  smoke sensor; 1 = smoke detected
- alarm  output  1  alarm enable; 1 = sound alarm
- extinguish  output  1  extinguisher enable; 1 = discharge

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset:
  - At a rising clk edge with reset=1, the state register becomes IDLE.
  - reset has priority over all transitions, including mid-operation from ALARM or EXTINGUISH.
  - While reset=1 the state stays IDLE regardless of the sensors.
- State register:
  - 2-bit register named current_state, so benches can probe it hierarchically.
  - next_state is computed combinationally from current_state, smoke_signal and heat_signal.
  - current_state is registered on rising clk.
- Transitions: one transition per clock at most, evaluated from the sampled inputs.
  - IDLE, smoke=1 -> ALARM. Heat alone does not leave IDLE. smoke=1 and heat=1 together also go only to ALARM, so reaching EXTINGUISH takes a minimum of two edges.
  - IDLE, smoke=0 -> stay IDLE.
  - ALARM, heat=1 -> EXTINGUISH, regardless of smoke.
  - ALARM, heat=0 and smoke=1 -> stay ALARM.
  - ALARM, heat=0 and smoke=0 -> IDLE.
  - EXTINGUISH, heat=1 -> stay EXTINGUISH, regardless of smoke.
  - EXTINGUISH, heat=0 and smoke=1 -> ALARM.
  - EXTINGUISH, heat=0 and smoke=0 -> IDLE.
  - Illegal encoding 2'b11 -> IDLE at the next edge. Outputs are both 0 in this state.
- Outputs are Moore, decoded combinationally from current_state only; no input-to-output combinational path.
  - IDLE: alarm=0, extinguish=0.
  - ALARM: alarm=1, extinguish=0.
  - EXTINGUISH: alarm=1, extinguish=1.
- Latency: an input change sampled at edge N is reflected on the outputs immediately after edge N, i.e. one-cycle latency from input setup.
- Reset values: alarm=0, extinguish=0.
- Inputs are assumed synchronous to clk. There is no internal synchronizer or debounce.
- Before the first reset the state is undefined (X in simulation); no power-on initializer is required.

Test Plan:
1. Reset: hold reset=1 for 2 edges with both sensors 0 -> current_state=00, alarm=0, extinguish=0. Raise smoke=1 while reset=1 -> stays 00.
2. Smoke only: reset=0, smoke=1 for 2 cycles -> state 01, alarm=1, extinguish=0. smoke=0 -> after the next edge state 00, both outputs 0.
3. Full fire: in IDLE set smoke=1 and heat=1 together -> first edge gives state 01 (alarm=1, extinguish=0); second edge gives 10 (alarm=1, extinguish=1); holds while heat=1.
4. Extinction: from EXTINGUISH set heat=0, keep smoke=1 -> state 01, alarm=1, extinguish=0. Then smoke=0 -> 00, both 0. Also from EXTINGUISH drop heat and smoke together -> 00 directly.
5. Heat alone: in IDLE set heat=1, smoke=0 for 3 cycles -> state remains 00, outputs 0.
6. Reset mid-operation: in EXTINGUISH assert reset=1 for one edge -> state 00, alarm=0, extinguish=0 at that edge, even with heat=1 and smoke=1. After reset drops with both sensors still 1 -> 01, then 10.
